// File: rtl/tc_pkg.sv
// Shared encodings for the traffic-controller light path: light codes,
// phases, monitor error codes and monitor FSM states.
package tc_pkg;

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_ENC  = 3'd1;
  localparam logic [2:0] ERR_PAIR = 3'd2;
  localparam logic [2:0] ERR_SEQ  = 3'd3;
  localparam logic [2:0] ERR_YEL  = 3'd4;
  localparam logic [2:0] ERR_GRN  = 3'd5;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    ERRST  = 2'd2
  } mon_state_t;

  // P1 and P3 are the yellow phases.
  function automatic logic is_yellow_phase(input phase_t p);
    return p[0];
  endfunction

endpackage

// File: rtl/tc_light_decode.sv
// Combinational decode of the two street light words into a phase and
// the encoding / pairing validity flags.
module tc_light_decode
  import tc_pkg::*;
(
  input  logic [2:0] i_l_a,
  input  logic [2:0] i_l_b,
  output phase_t     o_phase,
  output logic       o_onehot_ok,
  output logic       o_pair_ok
);

  assign o_onehot_ok = $onehot(i_l_a) && $onehot(i_l_b);

  always_comb begin
    o_phase   = P0;
    o_pair_ok = 1'b0;
    case ({i_l_a, i_l_b})
      {LT_GREEN,  LT_RED}:    begin o_phase = P0; o_pair_ok = 1'b1; end
      {LT_YELLOW, LT_RED}:    begin o_phase = P1; o_pair_ok = 1'b1; end
      {LT_RED,    LT_GREEN}:  begin o_phase = P2; o_pair_ok = 1'b1; end
      {LT_RED,    LT_YELLOW}: begin o_phase = P3; o_pair_ok = 1'b1; end
      default:                begin o_phase = P0; o_pair_ok = 1'b0; end
    endcase
  end

endmodule

// File: rtl/tc_light_monitor.sv
// Receive-side checker for the controller light outputs: tracks the phase
// sequence and dwell times per TICK and latches the first violation.
module tc_light_monitor
  import tc_pkg::*;
#(
  parameter int YELLOW_TICKS = 1,
  parameter int MIN_GREEN    = 1,
  parameter int DWELL_W      = 8,
  parameter int CYC_W        = 16
) (
  input  logic               CLK,
  input  logic               R,
  input  logic               TICK,
  input  logic               CLR,
  input  logic [2:0]         L_A,
  input  logic [2:0]         L_B,
  output logic [1:0]         PHASE,
  output logic               LOCKED,
  output logic [DWELL_W-1:0] DWELL,
  output logic [CYC_W-1:0]   CYCLES,
  output logic               ERR,
  output logic [2:0]         ERR_CODE,
  output logic [1:0]         DBG_STATE
);

  // TICK qualifies the sample: L_A/L_B are consumed on a CLK edge only when
  // TICK=1 (CLR takes precedence); there is no back-pressure toward the source.

  localparam logic [DWELL_W-1:0] LP_YEL       = DWELL_W'(YELLOW_TICKS);
  localparam logic [DWELL_W-1:0] LP_MIN_GRN   = DWELL_W'(MIN_GREEN);
  localparam logic [DWELL_W-1:0] LP_DWELL_MAX = '1;

  mon_state_t         r_state;
  phase_t             r_phase;
  logic [DWELL_W-1:0] r_dwell;
  logic [CYC_W-1:0]   r_cycles;
  logic [2:0]         r_code;
  logic               r_first;

  mon_state_t         w_state_nx;
  phase_t             w_phase_nx;
  logic [DWELL_W-1:0] w_dwell_nx;
  logic [CYC_W-1:0]   w_cycles_nx;
  logic [2:0]         w_code_nx;
  logic               w_first_nx;

  phase_t     w_dec_phase;
  logic       w_onehot_ok;
  logic       w_pair_ok;
  logic       w_same;
  logic       w_adv;
  logic [2:0] w_chk;

  tc_light_decode u_decode (
    .i_l_a       (L_A),
    .i_l_b       (L_B),
    .o_phase     (w_dec_phase),
    .o_onehot_ok (w_onehot_ok),
    .o_pair_ok   (w_pair_ok)
  );

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state  <= UNSYNC;
      r_phase  <= P0;
      r_dwell  <= '0;
      r_cycles <= '0;
      r_code   <= ERR_NONE;
      r_first  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_dwell  <= w_dwell_nx;
      r_cycles <= w_cycles_nx;
      r_code   <= w_code_nx;
      r_first  <= w_first_nx;
    end
  end

  // Exit-time dwell checks are skipped while the entry phase was only partly seen.
  always_comb begin
    w_same = (w_dec_phase == r_phase);
    w_adv  = (w_dec_phase == phase_t'(r_phase + 2'd1));
    w_chk  = ERR_NONE;
    if (!w_onehot_ok) begin
      w_chk = ERR_ENC;
    end else if (!w_pair_ok) begin
      w_chk = ERR_PAIR;
    end else if (!(w_same || w_adv)) begin
      w_chk = ERR_SEQ;
    end else if (is_yellow_phase(r_phase)) begin
      if (w_same && (r_dwell >= LP_YEL)) begin
        w_chk = ERR_YEL;
      end else if (w_adv && !r_first && (r_dwell != LP_YEL)) begin
        w_chk = ERR_YEL;
      end
    end else if (w_adv && !r_first && (r_dwell < LP_MIN_GRN)) begin
      w_chk = ERR_GRN;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_phase_nx  = r_phase;
    w_dwell_nx  = r_dwell;
    w_cycles_nx = r_cycles;
    w_code_nx   = r_code;
    w_first_nx  = r_first;
    if (CLR) begin
      w_state_nx = UNSYNC;
      w_code_nx  = ERR_NONE;
      w_dwell_nx = '0;
      w_first_nx = 1'b0;
    end else if (TICK) begin
      case (r_state)
        UNSYNC: begin
          if (w_onehot_ok && w_pair_ok) begin
            w_state_nx = TRACK;
            w_phase_nx = w_dec_phase;
            w_dwell_nx = DWELL_W'(1);
            w_first_nx = 1'b1;
          end
        end
        TRACK: begin
          if (w_chk != ERR_NONE) begin
            w_state_nx = ERRST;
            w_code_nx  = w_chk;
          end else if (w_same) begin
            if (r_dwell != LP_DWELL_MAX) w_dwell_nx = r_dwell + DWELL_W'(1);
          end else begin
            w_phase_nx = w_dec_phase;
            w_dwell_nx = DWELL_W'(1);
            w_first_nx = 1'b0;
            if (r_phase == P3) w_cycles_nx = r_cycles + CYC_W'(1);
          end
        end
        ERRST:   w_state_nx = ERRST;
        default: w_state_nx = UNSYNC;
      endcase
    end
  end

  always_comb begin
    PHASE     = r_phase;
    LOCKED    = (r_state == TRACK);
    DWELL     = r_dwell;
    CYCLES    = r_cycles;
    ERR       = (r_state == ERRST);
    ERR_CODE  = r_code;
    DBG_STATE = r_state;
  end

endmodule
